app_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single application-side input of the UDP/TCP send stack (`send_top`) between NUM_REQ application requesters. It latches one requester's frame descriptor, streams that requester's 32-bit payload words into `send_top`, and enforces an idle gap between frames. It sits between the application logic and `send_top` in the `clk` domain.

---
 rtl/app_tx_arbiter_pkg.sv | 23 ++
 rtl/app_tx_arbiter_rr_arbiter.sv | 32 +++
 rtl/app_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_app_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/app_tx_arbiter_pkg.sv
// Shared definitions for the application-side transmit arbiter feeding send_top.
package app_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [1:0] OP_UDP     = 2'd1;
    localparam logic [1:0] OP_TCP     = 2'd2;
    localparam int         WORD_BYTES = 4;

    // Rounds a byte length up to whole payload words; 0xFFFF gives 16384.
    function automatic logic [14:0] word_count(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'(WORD_BYTES - 1);
        sum = sum >> $clog2(WORD_BYTES);
        return sum[14:0];
    endfunction

endpackage

// File: rtl/app_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         pick_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    logic found;

    always_comb begin
        int j;
        j      = 0;
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!found && req_i[j]) begin
                found     = 1'b1;
                pick_o[j] = 1'b1;
                idx_o     = j[$clog2(NUM_REQ)-1:0];
            end
        end
    end

endmodule

// File: rtl/app_tx_arbiter.sv
// Round-robin scheduler sharing the send_top application input between NUM_REQ requesters.
//   state  | meaning
//   IDLE   | wait for any request, register the round-robin winner
//   LOAD   | latch the winner's descriptor and word count, reject zero length
//   STREAM | pass the winner's payload words through, one register stage
//   GAP    | force GAP_CYCLES idle cycles before the next arbitration
module app_tx_arbiter
    import app_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [2*NUM_REQ-1:0]    req_op,
    input  logic [32*NUM_REQ-1:0]   req_dest_ip,
    input  logic [16*NUM_REQ-1:0]   req_dest_port,
    input  logic [16*NUM_REQ-1:0]   req_length,
    input  logic [8*NUM_REQ-1:0]    req_tcp_ctrl,
    input  logic [NUM_REQ-1:0]      wr_valid,
    input  logic [32*NUM_REQ-1:0]   wr_data,
    output logic [NUM_REQ-1:0]      wr_ready,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      err,
    output logic                    data_from_app_valid,
    output logic [31:0]             data_from_app,
    output logic [1:0]              op,
    output logic [31:0]             dest_ip_addr,
    output logic [15:0]             dest_port,
    output logic [15:0]             data_from_app_length,
    output logic [7:0]              tcp_ctrl_type
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int GW   = $clog2(GAP_CYCLES + 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, done_q, done_d, err_q, err_d;
    logic [IDXW-1:0]     widx_q, widx_d, ptr_q, ptr_d;
    logic [14:0]         cnt_q, cnt_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [1:0]          op_q, op_d;
    logic [31:0]         ip_q, ip_d, data_q, data_d;
    logic [15:0]         port_q, port_d, len_q, len_d;
    logic [7:0]          tcp_q, tcp_d;
    logic                valid_q, valid_d;

    logic [NUM_REQ-1:0]  pick;
    logic [IDXW-1:0]     pick_idx;
    logic [15:0]         sel_len;
    logic                accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx)
    );

    assign sel_len  = req_length[16*widx_q +: 16];
    assign wr_ready = (state_q == STREAM) ? grant_q : '0;
    assign accept   = (state_q == STREAM) && wr_valid[widx_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        widx_d  = widx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        op_d    = op_q;
        ip_d    = ip_q;
        port_d  = port_q;
        len_d   = len_q;
        tcp_d   = tcp_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    widx_d  = pick_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                op_d   = req_op[2*widx_q +: 2];
                ip_d   = req_dest_ip[32*widx_q +: 32];
                port_d = req_dest_port[16*widx_q +: 16];
                len_d  = sel_len;
                tcp_d  = req_tcp_ctrl[8*widx_q +: 8];
                cnt_d  = word_count(sel_len);
                ptr_d  = (widx_q == IDXW'(NUM_REQ - 1)) ? '0 : widx_q + 1'b1;
                if (sel_len == '0) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    gap_d   = GW'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    data_d  = wr_data[32*widx_q +: 32];
                    valid_d = 1'b1;
                    cnt_d   = cnt_q - 15'd1;
                    if (cnt_q == 15'd1) begin
                        done_d  = grant_q;
                        grant_d = '0;
                        gap_d   = GW'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            widx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            op_q    <= '0;
            ip_q    <= '0;
            port_q  <= '0;
            len_q   <= '0;
            tcp_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            widx_q  <= widx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            op_q    <= op_d;
            ip_q    <= ip_d;
            port_q  <= port_d;
            len_q   <= len_d;
            tcp_q   <= tcp_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign grant                = grant_q;
    assign done                 = done_q;
    assign err                  = err_q;
    assign data_from_app_valid  = valid_q;
    assign data_from_app        = data_q;
    assign op                   = op_q;
    assign dest_ip_addr         = ip_q;
    assign dest_port            = port_q;
    assign data_from_app_length = len_q;
    assign tcp_ctrl_type        = tcp_q;

endmodule

// File: tb/tb_app_tx_arbiter.sv
// Scoreboard bench for app_tx_arbiter: directed frames push expectations, a monitor pops them.
module tb_app_tx_arbiter;
    import app_tx_arbiter_pkg::*;

    localparam int NR  = 4;
    localparam int GAP = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req, wr_valid, wr_ready, grant, done, err;
    logic [2*NR-1:0]   req_op;
    logic [32*NR-1:0]  req_dest_ip, wr_data;
    logic [16*NR-1:0]  req_dest_port, req_length;
    logic [8*NR-1:0]   req_tcp_ctrl;
    logic              data_from_app_valid;
    logic [31:0]       data_from_app, dest_ip_addr;
    logic [1:0]        op;
    logic [15:0]       dest_port, data_from_app_length;
    logic [7:0]        tcp_ctrl_type;

    app_tx_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req                  (req),
        .req_op               (req_op),
        .req_dest_ip          (req_dest_ip),
        .req_dest_port        (req_dest_port),
        .req_length           (req_length),
        .req_tcp_ctrl         (req_tcp_ctrl),
        .wr_valid             (wr_valid),
        .wr_data              (wr_data),
        .wr_ready             (wr_ready),
        .grant                (grant),
        .done                 (done),
        .err                  (err),
        .data_from_app_valid  (data_from_app_valid),
        .data_from_app        (data_from_app),
        .op                   (op),
        .dest_ip_addr         (dest_ip_addr),
        .dest_port            (dest_port),
        .data_from_app_length (data_from_app_length),
        .tcp_ctrl_type        (tcp_ctrl_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [31:0] data;
    } word_t;

    word_t         exp_word[$];
    logic [NR-1:0] exp_grant[$];
    logic [NR-1:0] exp_done[$];
    logic [NR-1:0] exp_err[$];
    int            exp_span[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] base_cfg[NR];
    int          stall_at[NR];
    int          stall_len[NR];
    int          req_frames[NR];
    bit          exact_gap = 1'b0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lo);
        checks++;
        if (act < lo) begin
            errors++;
            $display("FAIL %s got %0d expected at least %0d", name, act, lo);
        end
    endtask

    function automatic logic [73:0] desc_of(input int w);
        return {req_op[2*w +: 2], req_dest_ip[32*w +: 32], req_dest_port[16*w +: 16],
                req_length[16*w +: 16], req_tcp_ctrl[8*w +: 8]};
    endfunction

    function automatic logic [127:0] all_outs();
        return {grant, done, err, wr_ready, data_from_app_valid, data_from_app, op,
                dest_ip_addr, dest_port, data_from_app_length, tcp_ctrl_type};
    endfunction

    // Requester model: each requester raises req while it owes frames and supplies base+index words.
    initial begin : agent
        int wcnt[NR];
        int stall[NR];
        int served[NR];
        bit acc[NR];
        bit fin[NR];
        req      = '0;
        wr_valid = '0;
        wr_data  = '0;
        for (int i = 0; i < NR; i++) begin
            wcnt[i]   = 0;
            stall[i]  = 0;
            served[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                acc[i] = wr_valid[i] && wr_ready[i];
                fin[i] = done[i] || err[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!reset) begin
                    wcnt[i]  = 0;
                    stall[i] = 0;
                end else begin
                    if (acc[i]) wcnt[i]++;
                    if (fin[i]) begin
                        wcnt[i] = 0;
                        served[i]++;
                    end
                    if (stall[i] > 0) stall[i]--;
                    else if (acc[i] && stall_len[i] > 0 && wcnt[i] == stall_at[i]) stall[i] = stall_len[i];
                end
                req[i]            = served[i] < req_frames[i];
                wr_valid[i]       = req[i] && (stall[i] == 0);
                wr_data[32*i +: 32] = base_cfg[i] + 32'(wcnt[i]);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents grant, data, done or err.
    initial begin : monitor
        int            cyc = 0;
        int            first_cyc = 0;
        int            gap_ref = 0;
        bit            frame_open = 1'b0;
        bit            gap_pend = 1'b0;
        logic [NR-1:0] grant_prev = '0;
        word_t         w;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                frame_open = 1'b0;
                gap_pend   = 1'b0;
                grant_prev = '0;
            end else begin
                if (grant_prev == '0 && grant != '0) begin
                    if (exp_grant.size() == 0) check_eq("grant_unexpected", 128'(grant), 128'(0));
                    else check_eq("grant", 128'(grant), 128'(exp_grant.pop_front()));
                end
                grant_prev = grant;
                if (data_from_app_valid) begin
                    if (gap_pend) begin
                        if (exact_gap) check_eq("gap_exact", 128'(cyc - gap_ref), 128'(GAP + 3));
                        else check_ge("gap_min", cyc - gap_ref, GAP + 3);
                        gap_pend = 1'b0;
                    end
                    if (!frame_open) begin
                        frame_open = 1'b1;
                        first_cyc  = cyc;
                    end
                    if (exp_word.size() == 0) begin
                        check_eq("data_unexpected", 128'(data_from_app), 128'(0));
                    end else begin
                        w = exp_word.pop_front();
                        check_eq("data", 128'(data_from_app), 128'(w.data));
                        check_eq("descriptor", 128'({op, dest_ip_addr, dest_port, data_from_app_length, tcp_ctrl_type}),
                                 128'(desc_of(w.who)));
                    end
                end
                if (done != '0) begin
                    if (exp_done.size() == 0) check_eq("done_unexpected", 128'(done), 128'(0));
                    else begin
                        check_eq("done", 128'(done), 128'(exp_done.pop_front()));
                        check_eq("frame_span", 128'(cyc - first_cyc + 1), 128'(exp_span.pop_front()));
                    end
                    frame_open = 1'b0;
                    gap_pend   = 1'b1;
                    gap_ref    = cyc;
                end
                if (err != '0) begin
                    if (exp_err.size() == 0) check_eq("err_unexpected", 128'(err), 128'(0));
                    else check_eq("err", 128'(err), 128'(exp_err.pop_front()));
                    gap_pend = 1'b1;
                    gap_ref  = cyc;
                end
            end
        end
    end

    task automatic set_cfg(input int i, input logic [15:0] len, input logic [31:0] base);
        req_length[16*i +: 16]   = len;
        req_op[2*i +: 2]         = (i % 2 == 1) ? OP_TCP : OP_UDP;
        req_dest_ip[32*i +: 32]  = 32'hC0A8_0100 + 32'(i);
        req_dest_port[16*i +: 16] = 16'h1000 + 16'(i);
        req_tcp_ctrl[8*i +: 8]   = 8'h10 + 8'(i);
        base_cfg[i]              = base;
    endtask

    task automatic expect_frame(input int i, input int nwords, input int span);
        logic [NR-1:0] oh;
        word_t w;
        oh    = '0;
        oh[i] = 1'b1;
        exp_grant.push_back(oh);
        if (nwords == 0) begin
            exp_err.push_back(oh);
        end else begin
            for (int k = 0; k < nwords; k++) begin
                w.who  = i;
                w.data = base_cfg[i] + 32'(k);
                exp_word.push_back(w);
            end
            exp_done.push_back(oh);
            exp_span.push_back(span);
        end
    endtask

    function automatic int pending();
        return exp_word.size() + exp_grant.size() + exp_done.size() + exp_err.size();
    endfunction

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (pending() != 0 && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq({name, "_drained"}, 128'(pending()), 128'(0));
        repeat (GAP + 4) @(negedge clk);
    endtask

    task automatic do_reset();
        exact_gap = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            stall_at[i]  = 0;
            stall_len[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", all_outs(), 128'(0));
        reset = 1'b1;
    endtask

    initial begin : main
        int n;
        reset         = 1'b0;
        req_op        = '0;
        req_dest_ip   = '0;
        req_dest_port = '0;
        req_length    = '0;
        req_tcp_ctrl  = '0;
        for (int i = 0; i < NR; i++) begin
            base_cfg[i]   = '0;
            stall_at[i]   = 0;
            stall_len[i]  = 0;
            req_frames[i] = 0;
        end

        // Single 10-byte frame from requester 2.
        do_reset();
        set_cfg(2, 16'd10, 32'hA0);
        expect_frame(2, 3, 3);
        req_frames[2]++;
        drain("single", 200);

        // All four held: order 0,1,2,3,0 with exact inter-frame gap.
        do_reset();
        exact_gap = 1'b1;
        for (int i = 0; i < NR; i++) set_cfg(i, 16'd4, 32'h100 * 32'(i + 1));
        expect_frame(0, 1, 1);
        expect_frame(1, 1, 1);
        expect_frame(2, 1, 1);
        expect_frame(3, 1, 1);
        expect_frame(0, 1, 1);
        req_frames[0] += 2;
        for (int i = 1; i < NR; i++) req_frames[i]++;
        drain("round_robin", 400);

        // Five-cycle wr_valid stall after the second word of a 16-byte frame.
        do_reset();
        set_cfg(1, 16'd16, 32'h5000);
        stall_at[1]  = 2;
        stall_len[1] = 5;
        expect_frame(1, 4, 9);
        req_frames[1]++;
        drain("bubbles", 200);

        // Zero length on requester 1, then 0 and 2 together must start at 2.
        do_reset();
        set_cfg(1, 16'd0, 32'h0);
        expect_frame(1, 0, 0);
        req_frames[1]++;
        n = 0;
        while (pending() != 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("zero_len_err_seen", 128'(pending()), 128'(0));
        set_cfg(0, 16'd4, 32'h700);
        set_cfg(2, 16'd4, 32'h900);
        expect_frame(2, 1, 1);
        expect_frame(0, 1, 1);
        req_frames[0]++;
        req_frames[2]++;
        drain("zero_len", 300);

        // Maximum length frame.
        do_reset();
        set_cfg(0, 16'hFFFF, 32'h0);
        expect_frame(0, 16384, 16384);
        req_frames[0]++;
        drain("max_len", 17000);

        // Reset mid-frame, then the same requester restarts from word 0.
        do_reset();
        set_cfg(3, 16'd16, 32'h300);
        expect_frame(3, 4, 4);
        req_frames[3]++;
        n = 0;
        while (exp_word.size() > 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("mid_frame_two_words", 128'(exp_word.size()), 128'(2));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_reset_outputs", all_outs(), 128'(0));
        exp_word.delete();
        exp_grant.delete();
        exp_done.delete();
        exp_span.delete();
        exp_err.delete();
        repeat (3) @(negedge clk);
        expect_frame(3, 4, 4);
        reset = 1'b1;
        drain("reset_restart", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
